// File: rtl/dma_buffer_fill_if.sv
// Request/memory/buffer signal bundle between the FC burst-read engine and its user.
// The slave modport is the engine side; master is the requester plus memory side.
interface dma_buffer_fill_if #(
    parameter int BUFFER_SIZE       = 120,
    parameter int WORD_SIZE         = 16,
    parameter int MEM_ADDRESS_WIDTH = 3
);
    logic                                   i_read;
    logic [MEM_ADDRESS_WIDTH-1:0]           i_address;
    logic [MEM_ADDRESS_WIDTH-1:0]           i_count;
    logic [WORD_SIZE-1:0]                   i_mem_data;
    logic [MEM_ADDRESS_WIDTH-1:0]           o_mem_addr;
    logic [BUFFER_SIZE-1:0][WORD_SIZE-1:0]  o_buffer;
    logic                                   o_ready;

    modport master (
        output i_read, i_address, i_count, i_mem_data,
        input  o_mem_addr, o_buffer, o_ready
    );

    modport slave (
        input  i_read, i_address, i_count, i_mem_data,
        output o_mem_addr, o_buffer, o_ready
    );
endinterface

// File: rtl/dma_buffer_fill.sv
// Burst-read engine: fetches up to BUFFER_SIZE consecutive words from a combinational-read
// memory, one per cycle, into a wide buffer and flags completion with o_ready.
//
// state | meaning
// IDLE  | waiting for i_read; o_ready low
// BUSY  | fetching word base+idx into entry idx each cycle
// DONE  | buffer complete and frozen; o_ready high until i_read drops
module dma_buffer_fill #(
    parameter int BUFFER_SIZE       = 120,
    parameter int WORD_SIZE         = 16,
    parameter int MEM_ADDRESS_WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    dma_buffer_fill_if.slave   bus
);
    localparam int AW = MEM_ADDRESS_WIDTH;
    localparam logic [AW-1:0] ONE = AW'(1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                                state_q, state_d;
    logic [AW-1:0]                         base_q, base_d;
    logic [AW-1:0]                         idx_q, idx_d;
    logic [AW-1:0]                         len_q, len_d;
    logic [BUFFER_SIZE-1:0][WORD_SIZE-1:0] buf_q, buf_d;
    logic                                  ready_q, ready_d;
    logic [AW-1:0]                         len_req;

    // A count that can never exceed the buffer makes this clamp a no-op, but keeps it safe
    // for parameterisations where the count range is larger than the buffer.
    assign len_req = (int'(bus.i_count) > BUFFER_SIZE) ? AW'(BUFFER_SIZE) : bus.i_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            buf_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            buf_q   <= buf_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        idx_d   = idx_q;
        len_d   = len_q;
        buf_d   = buf_q;
        ready_d = ready_q;
        case (state_q)
            IDLE: begin
                ready_d = 1'b0;
                if (bus.i_read) begin
                    base_d = bus.i_address;
                    len_d  = len_req;
                    idx_d  = '0;
                    if (len_req != '0) begin
                        state_d = BUSY;
                    end else begin
                        state_d = DONE;
                        ready_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                buf_d[int'(idx_q)] = bus.i_mem_data;
                if (idx_q == len_q - ONE) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                end else begin
                    idx_d = idx_q + ONE;
                end
            end
            DONE: begin
                // Held-high i_read keeps us here so a stale request cannot retrigger.
                if (!bus.i_read) begin
                    state_d = IDLE;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b0;
            end
        endcase
    end

    assign bus.o_mem_addr = (state_q == BUSY) ? base_q + idx_q : base_q;
    assign bus.o_buffer   = buf_q;
    assign bus.o_ready    = ready_q;
endmodule

// File: tb/tb_dma_buffer_fill.sv
// Bench for dma_buffer_fill: directed transfers against an 8-word memory with mem[k]=k;
// expected buffers are queued at issue time and checked by a monitor on each o_ready rise.
module tb_dma_buffer_fill;
    localparam int BS = 120;
    localparam int WS = 16;
    localparam int AW = 3;

    typedef struct {
        logic [BS-1:0][WS-1:0] data;
        int                    lat;
        int                    start;
        string                 name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    logic [BS-1:0][WS-1:0] model_buf = '0;

    dma_buffer_fill_if #(.BUFFER_SIZE(BS), .WORD_SIZE(WS), .MEM_ADDRESS_WIDTH(AW)) bus ();

    dma_buffer_fill #(.BUFFER_SIZE(BS), .WORD_SIZE(WS), .MEM_ADDRESS_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign bus.i_mem_data = WS'(bus.o_mem_addr);

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic check_buf_zero(input string name);
        int bad;
        bad = -1;
        for (int k = 0; k < BS; k++)
            if (bus.o_buffer[k] != '0 && bad < 0) bad = k;
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s: entry %0d got %0d expected 0", name, bad, bus.o_buffer[bad]);
        end
    endtask

    // Monitor: every rising o_ready pops one expected transfer and compares buffer and latency.
    initial begin : monitor
        logic prev;
        exp_t e;
        int   bad;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_ready && !prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_ready: got ready at cycle %0d expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    bad = -1;
                    for (int k = 0; k < BS; k++)
                        if (bus.o_buffer[k] != e.data[k] && bad < 0) bad = k;
                    if (bad >= 0) begin
                        failures++;
                        $display("FAIL %s_buf: entry %0d got %0d expected %0d",
                                 e.name, bad, bus.o_buffer[bad], e.data[bad]);
                    end
                    check({e.name, "_latency"}, cyc - e.start, e.lat);
                end
            end
            prev = bus.o_ready;
        end
    end

    task automatic issue(input int addr, input int cnt, input string name);
        exp_t e;
        int   len;
        len = (cnt > BS) ? BS : cnt;
        for (int k = 0; k < len; k++) model_buf[k] = WS'((addr + k) % 8);
        e.data  = model_buf;
        e.lat   = len + 1;
        e.start = cyc;
        e.name  = name;
        exp_q.push_back(e);
        bus.i_address = AW'(addr);
        bus.i_count   = AW'(cnt);
        bus.i_read    = 1'b1;
    endtask

    task automatic wait_ready(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.o_ready) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no ready within 40 cycles expected ready", name);
            exp_q.delete();
        end
    endtask

    task automatic release_read(input string name);
        bus.i_read = 1'b0;
        @(negedge clk);
        check({name, "_ready_drop"}, int'(bus.o_ready), 0);
    endtask

    task automatic run(input int addr, input int cnt, input string name);
        issue(addr, cnt, name);
        wait_ready(name);
        release_read(name);
    endtask

    initial begin
        bus.i_read    = 1'b0;
        bus.i_address = '0;
        bus.i_count   = '0;
        #1;
        check("reset_ready", int'(bus.o_ready), 0);
        check("reset_addr", int'(bus.o_mem_addr), 0);
        check_buf_zero("reset_buf");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run(1, 4, "t1_basic");
        run(6, 4, "t2_wrap");
        check("t2_addr_holds_base", int'(bus.o_mem_addr), 6);
        run(0, 0, "t3_zero");

        issue(2, 3, "t4_hold");
        wait_ready("t4_hold");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_ready_held", int'(bus.o_ready), 1);
            check("t4_no_refetch_addr", int'(bus.o_mem_addr), 2);
        end
        release_read("t4_hold");
        run(0, 7, "t4_rerun");

        issue(3, 5, "t5_midchange");
        @(negedge clk);
        @(negedge clk);
        bus.i_address = 3'd7;
        bus.i_count   = 3'd1;
        wait_ready("t5_midchange");
        release_read("t5_midchange");

        bus.i_address = 3'd5;
        bus.i_count   = 3'd6;
        bus.i_read    = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_busy_addr", int'(bus.o_mem_addr), 7);
        rst = 1'b1;
        #1;
        check("t6_rst_ready", int'(bus.o_ready), 0);
        check("t6_rst_addr", int'(bus.o_mem_addr), 0);
        check_buf_zero("t6_rst_buf");
        bus.i_read = 1'b0;
        model_buf  = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(4, 2, "t6_after_reset");

        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
